dec_to_bin: RTL and testbench

DEC_TO_BIN -- requirements
Module: dec_to_bin

---
 rtl/dec_to_bin_if.sv | 28 ++
 rtl/dec_to_bin.sv | 126 ++++++++++++
 tb/tb_dec_to_bin.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dec_to_bin_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// Master drives a request, slave returns status and result.
interface dec_to_bin_if;
    logic        start;
    logic [15:0] bcd;
    logic        busy;
    logic        valid;
    logic [13:0] bin;
    logic        error;

    modport master (
        output start,
        output bcd,
        input  busy,
        input  valid,
        input  bin,
        input  error
    );

    modport slave (
        input  start,
        input  bcd,
        output busy,
        output valid,
        output bin,
        output error
    );
endinterface

// File: rtl/dec_to_bin.sv
// Four-digit BCD to 14-bit binary converter.
// Reverse double-dabble, one bit per cycle, 14 iterations.
module dec_to_bin (
    input  logic         clk,
    input  logic         reset_n,
    dec_to_bin_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_work;
    logic [13:0] r_sr;
    logic [3:0]  r_cnt;
    logic [13:0] r_bin;
    logic        r_error;

    logic [15:0] w_work_sh;
    logic [13:0] w_sr_sh;
    logic [15:0] w_work_adj;
    logic        w_bad;
    logic        w_last;

    // Undo the x2+carry step: a shifted nibble >= 8 came from a digit >= 5
    function automatic logic [3:0] f_adj(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    // Any nibble above 9 means the request is not legal BCD
    assign w_bad = (bus.bcd[15:12] > 4'd9) |
                   (bus.bcd[11:8]  > 4'd9) |
                   (bus.bcd[7:4]   > 4'd9) |
                   (bus.bcd[3:0]   > 4'd9);

    assign w_last = (r_cnt == 4'd13);

    // One shift-and-correct step of the working/binary pair
    always_comb begin
        {w_work_sh, w_sr_sh} = {1'b0, r_work, r_sr[13:1]};
        w_work_adj = {f_adj(w_work_sh[15:12]),
                      f_adj(w_work_sh[11:8]),
                      f_adj(w_work_sh[7:4]),
                      f_adj(w_work_sh[3:0])};
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_bad ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: capture, iterate, publish result on the last step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_work  <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_error <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_work  <= bus.bcd;
                        r_sr    <= '0;
                        r_cnt   <= '0;
                        r_error <= w_bad;
                        if (w_bad) begin
                            r_bin <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_work_adj;
                    r_sr   <= w_sr_sh;
                    r_cnt  <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_bin <= w_sr_sh;
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.valid = (r_state == S_DONE);
    assign bus.bin   = r_bin;
    assign bus.error = r_error;

endmodule

// File: tb/tb_dec_to_bin.sv
// Self-checking bench for dec_to_bin.
// Directed cases, held-start stream, mid-run reset, random sweep.
module tb_dec_to_bin;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    dec_to_bin_if bus ();

    dec_to_bin dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [13:0] prev_bin;

    function automatic logic [15:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    function automatic bit ref_bad(input logic [15:0] b);
        return (b[15:12] > 9) || (b[11:8] > 9) ||
               (b[7:4] > 9) || (b[3:0] > 9);
    endfunction

    function automatic int ref_val(input logic [15:0] b);
        if (ref_bad(b)) return 0;
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 +
               int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it through to completion
    task automatic run(input logic [15:0] v);
        int  k;
        bit  mid_ok;
        bit  bad;
        int  exp_bin;
        bad     = ref_bad(v);
        exp_bin = ref_val(v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.bcd   = 16'($urandom);
        mid_ok = 1'b1;
        k = 0;
        @(negedge clk);
        while (bus.valid !== 1'b1 && k < 40) begin
            if (bus.busy !== 1'b1 || bus.bin !== prev_bin ||
                bus.error !== 1'b0) mid_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("latency", k, bad ? 0 : 14);
        chk("mid_hold", 32'(mid_ok), 1);
        chk("busy_done", 32'(bus.busy), 1);
        chk("bin", 32'(bus.bin), exp_bin);
        chk("error", 32'(bus.error), 32'(bad));
        prev_bin = 14'(exp_bin);
        @(negedge clk);
        chk("valid_1cyc", 32'(bus.valid), 0);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("bin_hold", 32'(bus.bin), exp_bin);
    endtask

    initial begin
        int          q_val[$];
        int          q_due[$];
        int          free_at;
        bit          exp_v;
        bit          no_valid;
        logic [15:0] b;

        reset_n   = 1'b1;
        bus.start = 1'b0;
        bus.bcd   = '0;
        prev_bin  = '0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_bin", 32'(bus.bin), 0);
        chk("rst_error", 32'(bus.error), 0);
        @(negedge clk);
        reset_n = 1'b1;

        run(16'h9999);
        run(16'h1234);
        run(16'h0000);
        run(16'h12A4);
        run(16'h0042);
        run(16'h9999);

        // Reset in the middle of a conversion of 5678
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 16'h5678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_valid", 32'(bus.valid), 0);
        chk("abort_bin", 32'(bus.bin), 0);
        chk("abort_error", 32'(bus.error), 0);
        prev_bin = '0;
        @(negedge clk);
        reset_n  = 1'b1;
        no_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.valid !== 1'b0) no_valid = 1'b0;
        end
        chk("abort_no_valid", 32'(no_valid), 1);
        run(16'h0001);

        // Start held high, bcd changing every cycle
        free_at = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            exp_v = (q_due.size() > 0) && (q_due[0] == c);
            chk("held_valid", 32'(bus.valid), 32'(exp_v));
            if (exp_v) begin
                chk("held_bin", 32'(bus.bin), q_val[0]);
                prev_bin = 14'(q_val[0]);
                void'(q_val.pop_front());
                void'(q_due.pop_front());
            end
            b = rand_bcd();
            bus.bcd   = b;
            bus.start = (c != 47);
            if (c != 47 && c >= free_at) begin
                q_val.push_back(ref_val(b));
                q_due.push_back(c + 15);
                free_at = c + 16;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;

        // Random sweep, mostly legal with some illegal digits mixed in
        for (int i = 0; i < 1100; i++) begin
            if (i % 11 == 10) run(16'($urandom));
            else run(rand_bcd());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
